// File: rtl/hazard_ctrl.sv
// Hazard detection, EX operand forwarding and memory-wait freeze for a 5-stage pipeline; HAZARD_FORWARD_EN enables forwarding.
// Latency: all control outputs are combinational (0 cycles); only state, flush_pend and stall_cnt are registered.
// Backpressure: mem_busy freezes the back end and holds PC and IF/ID; a redirect seen while frozen is replayed as an IF/ID flush on release.
module hazard_ctrl (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs,
    input  logic [4:0]  id_rt,
    input  logic        id_uses_rt,
    input  logic        redirect,
    input  logic [4:0]  ex_rs,
    input  logic [4:0]  ex_rt,
    input  logic [4:0]  ex_rd,
    input  logic        ex_regwrite,
    input  logic        ex_memread,
    input  logic [4:0]  mem_rd,
    input  logic        mem_regwrite,
    input  logic [4:0]  wb_rd,
    input  logic        wb_regwrite,
    input  logic        mem_busy,
    output logic        pc_we,
    output logic        ifid_we,
    output logic        ifid_flush,
    output logic        idex_bubble,
    output logic        pipe_freeze,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic [15:0] stall_cnt
);

    typedef enum logic {RUN = 1'b0, MEMWAIT = 1'b1} state_t;

    state_t      state_q, state_d;
    logic        flush_pend_q, flush_pend_d;
    logic [15:0] stall_cnt_q, stall_cnt_d;

    logic        stall;
    logic        id_hit_ex;
    logic [1:0]  fwd_a_raw, fwd_b_raw;

    // r0 is hardwired, so it never produces a match.
    function automatic logic hit(input logic [4:0] src, input logic [4:0] dst, input logic we);
        return we && (dst != 5'd0) && (src == dst);
    endfunction

`ifdef HAZARD_FORWARD_EN
    always_comb begin
        id_hit_ex = hit(id_rs, ex_rd, ex_regwrite) || (id_uses_rt && hit(id_rt, ex_rd, ex_regwrite));
        stall     = ex_memread && id_hit_ex;
        fwd_a_raw = hit(ex_rs, mem_rd, mem_regwrite) ? 2'b10 :
                    hit(ex_rs, wb_rd, wb_regwrite)   ? 2'b01 : 2'b00;
        fwd_b_raw = hit(ex_rt, mem_rd, mem_regwrite) ? 2'b10 :
                    hit(ex_rt, wb_rd, wb_regwrite)   ? 2'b01 : 2'b00;
    end
`else
    logic id_hit_mem;
    logic unused_fwd_inputs;

    // Write-before-read register file: MEM/WB producers never need a stall.
    always_comb begin
        id_hit_ex  = hit(id_rs, ex_rd, ex_regwrite) || (id_uses_rt && hit(id_rt, ex_rd, ex_regwrite));
        id_hit_mem = hit(id_rs, mem_rd, mem_regwrite) || (id_uses_rt && hit(id_rt, mem_rd, mem_regwrite));
        stall      = id_hit_ex || id_hit_mem;
        fwd_a_raw  = 2'b00;
        fwd_b_raw  = 2'b00;
    end

    assign unused_fwd_inputs = ^{ex_rs, ex_rt, wb_rd, wb_regwrite, ex_memread};
`endif

    always_comb begin
        pc_we       = 1'b1;
        ifid_we     = 1'b1;
        ifid_flush  = 1'b0;
        idex_bubble = 1'b0;
        pipe_freeze = 1'b0;
        fwd_a       = fwd_a_raw;
        fwd_b       = fwd_b_raw;
        if (reset) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            pipe_freeze = 1'b1;
            fwd_a       = 2'b00;
            fwd_b       = 2'b00;
        end else if (mem_busy) begin
            pc_we       = 1'b0;
            ifid_we     = 1'b0;
            pipe_freeze = 1'b1;
        end else begin
            if (stall) begin
                pc_we       = 1'b0;
                ifid_we     = 1'b0;
                idex_bubble = 1'b1;
            end else if (redirect) begin
                ifid_flush = 1'b1;
            end
            if (state_q == MEMWAIT && flush_pend_q) begin
                ifid_flush = 1'b1;
            end
        end
    end

    // A redirect taken while frozen is remembered until the release cycle.
    always_comb begin
        state_d      = mem_busy ? MEMWAIT : RUN;
        flush_pend_d = mem_busy && (flush_pend_q || (redirect && !stall));
        stall_cnt_d  = stall_cnt_q;
        if (!pc_we && stall_cnt_q != 16'hFFFF) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= RUN;
            flush_pend_q <= 1'b0;
            stall_cnt_q  <= 16'd0;
        end else begin
            state_q      <= state_d;
            flush_pend_q <= flush_pend_d;
            stall_cnt_q  <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: stimulus pushes model expectations, a negedge monitor pops and compares.
module tb_hazard_ctrl;

    logic        clk;
    logic        reset;
    logic [4:0]  id_rs, id_rt, ex_rs, ex_rt, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rt, redirect, ex_regwrite, ex_memread;
    logic        mem_regwrite, wb_regwrite, mem_busy;
    logic        pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze;
    logic [1:0]  fwd_a, fwd_b;
    logic [15:0] stall_cnt;

    typedef struct packed {
        logic        pc_we;
        logic        ifid_we;
        logic        ifid_flush;
        logic        idex_bubble;
        logic        pipe_freeze;
        logic [1:0]  fwd_a;
        logic [1:0]  fwd_b;
        logic [15:0] cnt;
    } obs_t;

    typedef struct {
        string name;
        obs_t  o;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;
    bit   m_pend = 1'b0;
    int   m_cnt = 0;

    hazard_ctrl dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt), .redirect(redirect),
        .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_rd(ex_rd),
        .ex_regwrite(ex_regwrite), .ex_memread(ex_memread),
        .mem_rd(mem_rd), .mem_regwrite(mem_regwrite),
        .wb_rd(wb_rd), .wb_regwrite(wb_regwrite), .mem_busy(mem_busy),
        .pc_we(pc_we), .ifid_we(ifid_we), .ifid_flush(ifid_flush),
        .idex_bubble(idex_bubble), .pipe_freeze(pipe_freeze),
        .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Does the ID instruction read register r?
    function automatic bit needs(input logic [4:0] r);
        return (r != 5'd0) && (r == id_rs || (id_uses_rt && r == id_rt));
    endfunction

    // Where the EX operand in register r should come from.
    function automatic logic [1:0] fsel(input logic [4:0] r);
`ifdef HAZARD_FORWARD_EN
        if (r == 5'd0) return 2'b00;
        if (mem_regwrite && mem_rd == r) return 2'b10;
        if (wb_regwrite && wb_rd == r) return 2'b01;
        return 2'b00;
`else
        return (r == 5'd31 && r == 5'd0) ? 2'b11 : 2'b00;
`endif
    endfunction

    task automatic step(input string name);
        exp_t e;
        bit   stl;
        e.name = name;
`ifdef HAZARD_FORWARD_EN
        stl = ex_memread && ex_regwrite && needs(ex_rd);
`else
        stl = (ex_regwrite && needs(ex_rd)) || (mem_regwrite && needs(mem_rd));
`endif
        e.o.fwd_a       = fsel(ex_rs);
        e.o.fwd_b       = fsel(ex_rt);
        e.o.pc_we       = 1'b1;
        e.o.ifid_we     = 1'b1;
        e.o.ifid_flush  = 1'b0;
        e.o.idex_bubble = 1'b0;
        e.o.pipe_freeze = 1'b0;
        if (reset) begin
            m_pend = 1'b0;
            m_cnt  = 0;
            e.o.pc_we = 1'b0; e.o.ifid_we = 1'b0; e.o.pipe_freeze = 1'b1;
            e.o.fwd_a = 2'b00; e.o.fwd_b = 2'b00;
        end else if (mem_busy) begin
            e.o.pc_we = 1'b0; e.o.ifid_we = 1'b0; e.o.pipe_freeze = 1'b1;
        end else begin
            if (stl) begin
                e.o.pc_we = 1'b0; e.o.ifid_we = 1'b0; e.o.idex_bubble = 1'b1;
            end else if (redirect) begin
                e.o.ifid_flush = 1'b1;
            end
            if (m_pend) e.o.ifid_flush = 1'b1;
        end
        e.o.cnt = 16'(m_cnt);
        sb.push_back(e);
        if (!reset) begin
            if (!e.o.pc_we && m_cnt < 65535) m_cnt++;
            if (mem_busy) m_pend = m_pend || (redirect && !stl);
            else m_pend = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic clr();
        id_rs = 5'd0; id_rt = 5'd0; id_uses_rt = 1'b0; redirect = 1'b0;
        ex_rs = 5'd0; ex_rt = 5'd0; ex_rd = 5'd0; ex_regwrite = 1'b0; ex_memread = 1'b0;
        mem_rd = 5'd0; mem_regwrite = 1'b0; wb_rd = 5'd0; wb_regwrite = 1'b0; mem_busy = 1'b0;
    endtask

    always @(negedge clk) begin
        if (sb.size() != 0) begin
            exp_t e;
            obs_t a;
            e = sb.pop_front();
            a = {pc_we, ifid_we, ifid_flush, idex_bubble, pipe_freeze, fwd_a, fwd_b, stall_cnt};
            total++;
            if (a !== e.o) begin
                bad++;
                $display("FAIL %s @%0t: got pc_we=%b ifid_we=%b flush=%b bubble=%b freeze=%b fwd_a=%b fwd_b=%b cnt=%0d; want pc_we=%b ifid_we=%b flush=%b bubble=%b freeze=%b fwd_a=%b fwd_b=%b cnt=%0d",
                         e.name, $time, a.pc_we, a.ifid_we, a.ifid_flush, a.idex_bubble, a.pipe_freeze, a.fwd_a, a.fwd_b, a.cnt,
                         e.o.pc_we, e.o.ifid_we, e.o.ifid_flush, e.o.idex_bubble, e.o.pipe_freeze, e.o.fwd_a, e.o.fwd_b, e.o.cnt);
            end
        end
    end

    initial begin
        clr();
        reset = 1'b1;
        @(posedge clk);
        #1;
        ex_rs = 5'd2; mem_rd = 5'd2; mem_regwrite = 1'b1;
        step("reset_hold0");
        step("reset_hold1");
        reset = 1'b0;
        clr();
        step("idle");

        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs = 5'd5;
        step("load_use");
        clr();
        step("load_use_after");

        mem_rd = 5'd8; wb_rd = 5'd8; mem_regwrite = 1'b1; wb_regwrite = 1'b1; ex_rs = 5'd8;
        step("fwd_mem_prio");
        mem_regwrite = 1'b0;
        step("fwd_wb");
        clr();
        ex_rt = 5'd8; wb_rd = 5'd8; wb_regwrite = 1'b1;
        step("fwd_b_wb");

        clr();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; redirect = 1'b1;
        step("stall_over_redirect");
        clr();
        redirect = 1'b1;
        step("redirect_flush");

        clr();
        mem_busy = 1'b1; redirect = 1'b1;
        step("busy1");
        redirect = 1'b0;
        step("busy2");
        step("busy3");
        mem_busy = 1'b0;
        step("busy_release");
        step("after_release");

        mem_busy = 1'b1; redirect = 1'b1;
        step("busy_pend");
        redirect = 1'b0; reset = 1'b1;
        step("reset_mid_wait");
        reset = 1'b0; mem_busy = 1'b0;
        step("release_after_reset");

        clr();
        mem_regwrite = 1'b1; mem_rd = 5'd3; id_rt = 5'd3; id_uses_rt = 1'b1;
        step("rt_mem_hazard");
        id_uses_rt = 1'b0;
        step("rt_unused");
        clr();
        ex_memread = 1'b1; ex_regwrite = 1'b1; ex_rd = 5'd0; id_rs = 5'd0;
        step("r0_no_stall");

        for (int i = 0; i < 3000; i++) begin
            reset        = ($urandom_range(0, 199) == 0);
            id_rs        = 5'($urandom_range(0, 3));
            id_rt        = 5'($urandom_range(0, 3));
            ex_rs        = 5'($urandom_range(0, 3));
            ex_rt        = 5'($urandom_range(0, 3));
            ex_rd        = 5'($urandom_range(0, 3));
            mem_rd       = 5'($urandom_range(0, 3));
            wb_rd        = 5'($urandom_range(0, 3));
            id_uses_rt   = 1'($urandom_range(0, 1));
            redirect     = ($urandom_range(0, 2) == 0);
            ex_regwrite  = 1'($urandom_range(0, 1));
            ex_memread   = 1'($urandom_range(0, 1));
            mem_regwrite = 1'($urandom_range(0, 1));
            wb_regwrite  = 1'($urandom_range(0, 1));
            mem_busy     = ($urandom_range(0, 4) == 0);
            step("rand");
        end

        reset = 1'b0;
        clr();
        mem_busy = 1'b1;
        for (int i = 0; i < 65540; i++) step("saturate");
        mem_busy = 1'b0;
        step("saturate_release");

        for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            total++;
            bad++;
            $display("FAIL drain: %0d expectations left unchecked, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Clock and reset SHALL be `clk` and `reset`: one clock, reset asynchronous and active-high.
REQ-002 Ports (name  direction  width  meaning) SHALL be:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-high reset.
- id_rs, id_rt  in  5 each  source registers of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt (R-type, store, branch).
- redirect  in  1  ID resolved a taken branch, jump, jal, jr or jalr.
- ex_rs, ex_rt  in  5 each  sources of the instruction in EX.
- ex_rd  in  5  destination of the instruction in EX.
- ex_regwrite, ex_memread  in  1 each  EX-stage control.
- mem_rd  in  5  destination in EX/MEM.
- mem_regwrite  in  1  EX/MEM write enable.
- wb_rd  in  5  destination in MEM/WB.
- wb_regwrite  in  1  MEM/WB write enable.
- mem_busy  in  1  data memory not ready.
- pc_we  out  1  PC load enable.
- ifid_we  out  1  IF/ID load enable.
- ifid_flush  out  1  clear IF/ID to NOP.
- idex_bubble  out  1  zero ID/EX control.
- pipe_freeze  out  1  hold ID/EX, EX/MEM and MEM/WB.
- fwd_a, fwd_b  out  2 each  ALU operand select: 00 = register file, 10 = EX/MEM, 01 = MEM/WB.
- stall_cnt  out  16  count of stalled cycles.

Function
REQ-003 Register 0 SHALL never create a hazard or a forward.
REQ-004 A source register SHALL match a destination only when the destination equals it, the destination is nonzero and that destination's write enable is 1. rt SHALL be considered only when id_uses_rt=1.
REQ-005 The stall condition (stall) SHALL be, with forwarding: ex_memread=1 and ex_regwrite=1 and ex_rd matches a used ID source.
REQ-006 Forwarding SHALL set fwd_a to 10 when mem_rd matches ex_rs; else to 01 when wb_rd matches ex_rs; else to 00. fwd_b SHALL follow the same rule using ex_rt. EX/MEM SHALL have priority over MEM/WB.
REQ-007 The FSM SHALL have two states, RUN and MEMWAIT, plus a sticky flag flush_pend.
REQ-008 In RUN with mem_busy=0 and stall=1: pc_we=0, ifid_we=0, idex_bubble=1, ifid_flush=0, and redirect SHALL be ignored. Stall SHALL win over redirect in the same cycle.
REQ-009 In RUN with mem_busy=0, stall=0 and redirect=1: pc_we=1, ifid_we=1, ifid_flush=1, idex_bubble=0.
REQ-010 In RUN with no event: pc_we=1, ifid_we=1, and all other control outputs 0.
REQ-011 In RUN, mem_busy=1 SHALL assert pipe_freeze=1, pc_we=0, ifid_we=0, idex_bubble=0 and move to MEMWAIT. A same-cycle redirect with stall=0 SHALL set flush_pend.
REQ-012 In MEMWAIT, outputs SHALL equal the freeze outputs of REQ-011 while mem_busy=1. A redirect with stall=0 SHALL set flush_pend.
REQ-013 In MEMWAIT with mem_busy=0, the FSM SHALL return to RUN. In that same cycle, outputs SHALL follow REQ-008 to REQ-010, with ifid_flush additionally forced to 1 when flush_pend=1; flush_pend SHALL then clear.
REQ-014 All control outputs SHALL be combinational from the FSM state and the inputs; hazard response latency SHALL be 0 cycles.
REQ-015 stall_cnt SHALL increment by 1 on every clock edge where pc_we=0 and reset=0, and SHALL saturate at 16'hFFFF with no wrap.

Reset
REQ-016 Reset SHALL force the state to RUN, flush_pend to 0 and stall_cnt to 0, asynchronously.
REQ-017 While reset=1, outputs SHALL be pc_we=0, ifid_we=0, pipe_freeze=1, ifid_flush=0, idex_bubble=0, fwd_a=00, fwd_b=00.
REQ-018 Reset asserted mid-MEMWAIT SHALL discard any pending flush.

Configuration
REQ-019 Macro HAZARD_FORWARD_EN SHALL control forwarding:
- Defined: REQ-005 and REQ-006 apply.
- Undefined: fwd_a and fwd_b SHALL be tied to 00, and stall SHALL be 1 whenever a used ID source matches ex_rd (ex_regwrite) or mem_rd (mem_regwrite), regardless of memread. The register file writes before it reads, so MEM/WB SHALL never stall.

Verification
REQ-020 ex_memread=1, ex_regwrite=1, ex_rd=5, id_rs=5 -> one cycle of pc_we=0, ifid_we=0, idex_bubble=1, and stall_cnt increments by 1.
REQ-021 (forwarding enabled) mem_rd=8 and wb_rd=8, both writes enabled, ex_rs=8, ex_rt=0 -> fwd_a=10 and fwd_b=00. Repeat with mem_regwrite=0 -> fwd_a=01.
REQ-022 redirect=1 together with the REQ-020 load-use condition -> stall only, ifid_flush=0. Next cycle, hazard gone, redirect=1 -> ifid_flush=1, pc_we=1.
REQ-023 mem_busy=1 for 3 cycles with redirect=1 in the first -> pipe_freeze=1 for those 3 cycles. In the release cycle, ifid_flush=1 and the FSM is in RUN. stall_cnt increases by 3.
REQ-024 Reset pulsed during MEMWAIT with flush_pend=1 -> after release, ifid_flush=0, stall_cnt=0, state RUN.
REQ-025 (forwarding disabled) mem_regwrite=1, mem_rd=3, id_rt=3, id_uses_rt=1 -> stall=1. Same stimulus with id_uses_rt=0 -> no stall.
